// File: rtl/instr_mem_pipe.sv
// Fetch-stage instruction memory: DEPTH x IW array with a program-load write port
// and a READ_LAT-deep registered read path with stall, flush and address checking.
module instr_mem_pipe #(
    parameter int            IW       = 16,
    parameter int            AW       = 6,
    parameter int            DEPTH    = 64,
    parameter int            PC_SHIFT = 0,
    parameter int            READ_LAT = 1,
    parameter logic [IW-1:0] NOP      = '0
) (
    input  logic                   CLOCK,
    input  logic                   in_rst_n,
    input  logic [AW-1:0]          in_pc,
    input  logic                   in_rd_en,
    input  logic                   in_stall,
    input  logic                   in_flush,
    input  logic                   in_wr_en,
    input  logic [AW-PC_SHIFT-1:0] in_wr_addr,
    input  logic [IW-1:0]          in_wr_data,
    output logic [IW-1:0]          out_instrn,
    output logic [AW-1:0]          out_pc,
    output logic                   out_valid,
    output logic                   out_addr_err
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0]     mem [DEPTH];
    logic [MEM_AW-1:0] rd_idx;
    logic              rd_err;

    logic [IW-1:0]     instrn_p1;
    logic [AW-1:0]     pc_p1;
    logic              vld_p1;
    logic              err_p1;

    // Misaligned low PC bits or a word index past the end of the array.
    function automatic logic fetch_err(input logic [AW-1:0] pc);
        logic [AW-1:0] align_mask;
        align_mask = AW'((1 << PC_SHIFT) - 1);
        return ((pc & align_mask) != '0) || (32'(pc >> PC_SHIFT) >= DEPTH);
    endfunction

    assign rd_idx = in_pc[PC_SHIFT +: MEM_AW];
    assign rd_err = fetch_err(in_pc);

    always_ff @(posedge CLOCK) begin
        if (in_wr_en && (32'(in_wr_addr) < DEPTH)) begin
            mem[in_wr_addr[MEM_AW-1:0]] <= in_wr_data;
        end
    end

    // Stage 1: array read (read-first against a same-edge write)
    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            instrn_p1 <= NOP;
            pc_p1     <= '0;
            vld_p1    <= 1'b0;
            err_p1    <= 1'b0;
        end else if (in_flush) begin
            instrn_p1 <= NOP;
            vld_p1    <= 1'b0;
            err_p1    <= 1'b0;
        end else if (!in_stall) begin
            if (in_rd_en) begin
                instrn_p1 <= rd_err ? NOP : mem[rd_idx];
                pc_p1     <= in_pc;
                vld_p1    <= 1'b1;
                err_p1    <= rd_err;
            end else begin
                instrn_p1 <= NOP;
                vld_p1    <= 1'b0;
                err_p1    <= 1'b0;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [IW-1:0] instrn_p2;
            logic [AW-1:0] pc_p2;
            logic          vld_p2;
            logic          err_p2;

            // Stage 2: output register, moves in lockstep with stage 1
            always_ff @(posedge CLOCK or negedge in_rst_n) begin
                if (!in_rst_n) begin
                    instrn_p2 <= NOP;
                    pc_p2     <= '0;
                    vld_p2    <= 1'b0;
                    err_p2    <= 1'b0;
                end else if (in_flush) begin
                    instrn_p2 <= NOP;
                    vld_p2    <= 1'b0;
                    err_p2    <= 1'b0;
                end else if (!in_stall) begin
                    instrn_p2 <= instrn_p1;
                    pc_p2     <= pc_p1;
                    vld_p2    <= vld_p1;
                    err_p2    <= err_p1;
                end
            end

            assign out_instrn   = instrn_p2;
            assign out_pc       = pc_p2;
            assign out_valid    = vld_p2;
            assign out_addr_err = err_p2;
        end else begin : g_lat1
            assign out_instrn   = instrn_p1;
            assign out_pc       = pc_p1;
            assign out_valid    = vld_p1;
            assign out_addr_err = err_p1;
        end
    endgenerate

endmodule
